scaler_h_ctrl: RTL and testbench

- Sequences and configures the horizontal scaler (scaler_h).
- Converts host geometry (input width, output width) into the scaler's fixed-point scale_step with an iterative divider.
- Applies the new step only at a frame boundary.
- Converts level-style de/hs/vs video into the registered, pulse-style strobes scaler_h consumes, and gates frames until a valid step exists.

---
 rtl/scaler_pkg.sv | 19 +
 rtl/scaler_step_div.sv | 76 +++++++
 rtl/scaler_h_ctrl.sv | 131 +++++++++++++
 tb/tb_scaler_h_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared definitions for the horizontal scaler and its controller:
// FSM states, step saturation value and the default geometry widths.
package scaler_pkg;

    localparam int STEP_W = 16;
    localparam int DIM_W  = 12;

    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    typedef logic [STEP_W-1:0] step_t;
    typedef logic [DIM_W-1:0]  dim_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        PEND = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/scaler_step_div.sv
// Iterative restoring divider producing a STEP_WIDTH quotient, one bit per clock.
// Quotients wider than STEP_WIDTH saturate to all-ones and raise sat.
import scaler_pkg::*;

module scaler_step_div #(
    parameter int STEP_WIDTH = STEP_W,
    parameter int DIM_WIDTH  = DIM_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [STEP_WIDTH+DIM_WIDTH-1:0] num,
    input  logic [DIM_WIDTH-1:0]            den,
    output logic                            done,
    output logic [STEP_WIDTH-1:0]           quot,
    output logic                            sat
);

    localparam int NUM_W = STEP_WIDTH + DIM_WIDTH;
    localparam int CNT_W = $clog2(NUM_W + 1);

    logic                 busy;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_W-1:0]     num_sh;
    logic [NUM_W-1:0]     q;
    logic [DIM_WIDTH-1:0] den_r;
    logic [DIM_WIDTH-1:0] rem;
    logic [DIM_WIDTH:0]   trial;
    logic [DIM_WIDTH-1:0] rem_next;
    logic                 qbit;

    always_comb begin
        trial    = {rem, num_sh[NUM_W-1]};
        qbit     = 1'b0;
        rem_next = trial[DIM_WIDTH-1:0];
        if (trial >= {1'b0, den_r}) begin
            qbit     = 1'b1;
            rem_next = DIM_WIDTH'(trial - {1'b0, den_r});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            num_sh <= '0;
            q      <= '0;
            den_r  <= '0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy   <= 1'b1;
                cnt    <= CNT_W'(NUM_W);
                num_sh <= num;
                den_r  <= den;
                q      <= '0;
                rem    <= '0;
            end else if (busy) begin
                rem    <= rem_next;
                num_sh <= {num_sh[NUM_W-2:0], 1'b0};
                q      <= {q[NUM_W-2:0], qbit};
                cnt    <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign sat  = |q[NUM_W-1:STEP_WIDTH];
    assign quot = sat ? '1 : q[STEP_WIDTH-1:0];

endmodule

// File: rtl/scaler_h_ctrl.sv
// Configuration sequencer and video front end for scaler_h: computes the scale
// step from host geometry, applies it at frame start and gates unscalable frames.
import scaler_pkg::*;

module scaler_h_ctrl #(
    parameter int PIXEL_STEP  = 128,
    parameter int PIXEL_WIDTH = 8,
    parameter int STEP_WIDTH  = STEP_W,
    parameter int DIM_WIDTH   = DIM_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIM_WIDTH-1:0]   cfg_in_w,
    input  logic [DIM_WIDTH-1:0]   cfg_out_w,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   cfg_err,
    output logic                   step_valid,
    output logic [STEP_WIDTH-1:0]  scale_step,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic [DIM_WIDTH-1:0]   line_cnt
);

    localparam int NUM_W      = STEP_WIDTH + DIM_WIDTH;
    localparam int STEP_SHIFT = $clog2(PIXEL_STEP);

    ctrl_state_t           state;
    logic [STEP_WIDTH-1:0] result;
    logic                  accept;
    logic                  div_start;
    logic                  div_done;
    logic                  div_sat;
    logic [STEP_WIDTH-1:0] div_quot;
    logic [NUM_W-1:0]      div_num;

    logic hs_prev, vs_prev, frame_en;
    logic vs_rise, hs_fall, apply, en_now;

    assign cfg_ready = (state == IDLE);
    assign accept    = cfg_valid & cfg_ready;
    assign div_start = accept & (cfg_out_w != '0);
    assign div_num   = NUM_W'(cfg_in_w) << STEP_SHIFT;

    scaler_step_div #(
        .STEP_WIDTH (STEP_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (div_num),
        .den   (cfg_out_w),
        .done  (div_done),
        .quot  (div_quot),
        .sat   (div_sat)
    );

    assign vs_rise = ~vs_prev & vs_i;
    assign hs_fall = hs_prev & ~hs_i;
    assign apply   = (state == PEND) & vs_rise;
    // A step applied on this very edge already enables the frame it starts.
    assign en_now  = vs_rise ? (step_valid | apply) : frame_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cfg_err    <= 1'b0;
            step_valid <= 1'b0;
            scale_step <= '0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cfg_out_w == '0) cfg_err <= 1'b1;
                        else                 state   <= DIV;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        result  <= div_quot;
                        cfg_err <= div_sat;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    if (vs_rise) begin
                        scale_step <= result;
                        step_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            do_o     <= '0;
            de_o     <= 1'b0;
            hs_o     <= 1'b0;
            vs_o     <= 1'b0;
            line_cnt <= '0;
            hs_prev  <= 1'b1;
            vs_prev  <= 1'b0;
            frame_en <= 1'b0;
        end else begin
            do_o    <= di_i;
            de_o    <= de_i & en_now;
            hs_o    <= hs_fall & en_now;
            vs_o    <= vs_rise & en_now;
            hs_prev <= hs_i;
            vs_prev <= vs_i;
            if (vs_rise) frame_en <= step_valid | apply;
            if (vs_rise & en_now) begin
                line_cnt <= (hs_fall) ? DIM_WIDTH'(1) : '0;
            end else if (hs_fall & en_now & (line_cnt != '1)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Scoreboard bench for scaler_h_ctrl: a cycle model pushes expected outputs per
// driven cycle; a negedge monitor pops and compares them against the DUT.
module tb_scaler_h_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cfg_in_w, cfg_out_w;
    logic        cfg_valid, cfg_ready, cfg_err, step_valid;
    logic [15:0] scale_step;
    logic [7:0]  di_i, do_o;
    logic        de_i, hs_i, vs_i, de_o, hs_o, vs_o;
    logic [11:0] line_cnt;

    scaler_h_ctrl #(
        .PIXEL_STEP  (128),
        .PIXEL_WIDTH (8),
        .STEP_WIDTH  (16),
        .DIM_WIDTH   (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_in_w   (cfg_in_w),
        .cfg_out_w  (cfg_out_w),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .step_valid (step_valid),
        .scale_step (scale_step),
        .di_i       (di_i),
        .de_i       (de_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .do_o       (do_o),
        .de_o       (de_o),
        .hs_o       (hs_o),
        .vs_o       (vs_o),
        .line_cnt   (line_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        de, hs, vs;
        logic [7:0]  d;
        logic [11:0] lc;
        logic [15:0] step;
        logic        sv, ready, err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   obs_de = 0, obs_hs = 0, obs_vs = 0, in_de = 0;

    // reference model state
    bit          m_hs_prev, m_vs_prev, m_fen, m_sv, m_busy, m_pend, m_err, m_psat;
    int          m_cnt;
    logic [15:0] m_step, m_pval;
    logic [11:0] m_lc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            total += 9;
            if (de_o !== mon_e.de) begin bad++; $display("FAIL de_o cyc=%0d got=%b want=%b", cyc, de_o, mon_e.de); end
            if (hs_o !== mon_e.hs) begin bad++; $display("FAIL hs_o cyc=%0d got=%b want=%b", cyc, hs_o, mon_e.hs); end
            if (vs_o !== mon_e.vs) begin bad++; $display("FAIL vs_o cyc=%0d got=%b want=%b", cyc, vs_o, mon_e.vs); end
            if (do_o !== mon_e.d) begin bad++; $display("FAIL do_o cyc=%0d got=%0h want=%0h", cyc, do_o, mon_e.d); end
            if (line_cnt !== mon_e.lc) begin bad++; $display("FAIL line_cnt cyc=%0d got=%0d want=%0d", cyc, line_cnt, mon_e.lc); end
            if (scale_step !== mon_e.step) begin bad++; $display("FAIL scale_step cyc=%0d got=%0d want=%0d", cyc, scale_step, mon_e.step); end
            if (step_valid !== mon_e.sv) begin bad++; $display("FAIL step_valid cyc=%0d got=%b want=%b", cyc, step_valid, mon_e.sv); end
            if (cfg_ready !== mon_e.ready) begin bad++; $display("FAIL cfg_ready cyc=%0d got=%b want=%b", cyc, cfg_ready, mon_e.ready); end
            if (cfg_err !== mon_e.err) begin bad++; $display("FAIL cfg_err cyc=%0d got=%b want=%b", cyc, cfg_err, mon_e.err); end
            obs_de += int'(de_o);
            obs_hs += int'(hs_o);
            obs_vs += int'(vs_o);
        end
    end

    function automatic void model_reset();
        m_hs_prev = 1; m_vs_prev = 0; m_fen = 0; m_sv = 0; m_busy = 0;
        m_pend = 0; m_err = 0; m_psat = 0; m_cnt = 0;
        m_step = '0; m_pval = '0; m_lc = '0;
    endfunction

    task automatic clear_counts();
        obs_de = 0; obs_hs = 0; obs_vs = 0; in_de = 0;
    endtask

    task automatic post_cfg(input int iw, input int ow);
        cfg_in_w  = 12'(iw);
        cfg_out_w = 12'(ow);
        cfg_valid = 1'b1;
    endtask

    task automatic drive_cycle(input logic de, input logic hs, input logic vs);
        exp_t        e;
        logic        vr, hf, en, rdy0, acc;
        logic [7:0]  d;
        longint      q;
        d    = 8'($urandom);
        rdy0 = !m_busy;
        vr   = !m_vs_prev && vs;
        hf   = m_hs_prev && !hs;
        if (vr && m_pend) begin
            m_step = m_pval; m_sv = 1; m_pend = 0; m_busy = 0;
        end
        en = vr ? m_sv : m_fen;
        if (vr) m_fen = m_sv;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin m_pend = 1; m_err = m_psat; end
        end
        acc = cfg_valid && rdy0;
        if (acc) begin
            if (cfg_out_w == 0) m_err = 1;
            else begin
                q      = (longint'(cfg_in_w) * 128) / longint'(cfg_out_w);
                m_psat = (q > 65535);
                m_pval = m_psat ? 16'hFFFF : 16'(q);
                m_busy = 1;
                m_cnt  = 29;
            end
        end
        if (vr && en) m_lc = hf ? 12'd1 : 12'd0;
        else if (hf && en && m_lc != 12'hFFF) m_lc = m_lc + 12'd1;
        m_hs_prev = hs;
        m_vs_prev = vs;
        e.cyc = cyc + 1; e.de = de & en; e.hs = hf & en; e.vs = vr & en; e.d = d;
        e.lc = m_lc; e.step = m_step; e.sv = m_sv; e.ready = !m_busy; e.err = m_err;
        sb.push_back(e);
        de_i = de; hs_i = hs; vs_i = vs; di_i = d;
        if (de) in_de++;
        @(posedge clk); #1;
        if (acc) cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input int lines, input int width, input int cfg_line,
                              input int iw, input int ow, input bit sim);
        for (int l = 0; l < lines; l++) begin
            if (l == cfg_line) post_cfg(iw, ow);
            if (!(sim && l == 0)) drive_cycle(1'b0, 1'b1, 1'b1);
            for (int p = 0; p < width; p++) drive_cycle(1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic apply_reset();
        exp_t e;
        rst = 1'b1; de_i = 0; hs_i = 1; vs_i = 0; di_i = '0; cfg_valid = 0;
        model_reset();
        e.cyc = cyc + 1; e.de = 0; e.hs = 0; e.vs = 0; e.d = '0; e.lc = '0;
        e.step = '0; e.sv = 0; e.ready = 1; e.err = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        idle(3);
        total += 2;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
        if (scale_step !== 16'd0) begin bad++; $display("FAIL reset_step got=%0d want=0", scale_step); end
    endtask

    task automatic test_gating();
        clear_counts();
        send_frame(4, 3, -1, 0, 0, 0);
        total += 3;
        if (obs_de != 0) begin bad++; $display("FAIL gated_de got=%0d want=0", obs_de); end
        if (obs_hs != 0) begin bad++; $display("FAIL gated_hs got=%0d want=0", obs_hs); end
        if (obs_vs != 0) begin bad++; $display("FAIL gated_vs got=%0d want=0", obs_vs); end
    endtask

    task automatic test_first_cfg();
        post_cfg(700, 500);
        idle(30);
        total += 1;
        if (scale_step !== 16'd0) begin bad++; $display("FAIL pre_frame_step got=%0d want=0", scale_step); end
        clear_counts();
        send_frame(3, 4, -1, 0, 0, 0);
        total += 4;
        if (scale_step !== 16'd179) begin bad++; $display("FAIL first_step got=%0d want=179", scale_step); end
        if (obs_de != in_de) begin bad++; $display("FAIL first_de_count got=%0d want=%0d", obs_de, in_de); end
        if (obs_vs != 1) begin bad++; $display("FAIL first_vs_count got=%0d want=1", obs_vs); end
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL first_err got=%b want=0", cfg_err); end
    endtask

    task automatic test_reconfig();
        send_frame(10, 4, 2, 500, 1000, 0);
        total += 1;
        if (scale_step !== 16'd179) begin bad++; $display("FAIL midframe_step got=%0d want=179", scale_step); end
        send_frame(2, 4, -1, 0, 0, 0);
        total += 2;
        if (scale_step !== 16'd64) begin bad++; $display("FAIL reconfig_step got=%0d want=64", scale_step); end
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reconfig_ready got=%b want=1", cfg_ready); end
    endtask

    task automatic test_bad_cfg();
        post_cfg(10, 0);
        idle(3);
        total += 3;
        if (cfg_err !== 1'b1) begin bad++; $display("FAIL zero_err got=%b want=1", cfg_err); end
        if (scale_step !== 16'd64) begin bad++; $display("FAIL zero_step got=%0d want=64", scale_step); end
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b want=1", cfg_ready); end
        post_cfg(4095, 1);
        idle(30);
        send_frame(2, 2, -1, 0, 0, 0);
        total += 2;
        if (scale_step !== 16'hFFFF) begin bad++; $display("FAIL sat_step got=%0d want=65535", scale_step); end
        if (cfg_err !== 1'b1) begin bad++; $display("FAIL sat_err got=%b want=1", cfg_err); end
    endtask

    task automatic test_lines();
        clear_counts();
        send_frame(600, 1, -1, 0, 0, 0);
        total += 2;
        if (obs_hs != 600) begin bad++; $display("FAIL hs_count got=%0d want=600", obs_hs); end
        if (line_cnt !== 12'd600) begin bad++; $display("FAIL line_cnt_end got=%0d want=600", line_cnt); end
        send_frame(2, 2, -1, 0, 0, 0);
        // frame whose first cycle is both vs rise and hs fall
        send_frame(3, 2, -1, 0, 0, 1);
        total += 1;
        if (line_cnt !== 12'd3) begin bad++; $display("FAIL sim_edge_lines got=%0d want=3", line_cnt); end
    endtask

    task automatic test_rst_div();
        post_cfg(300, 100);
        idle(5);
        apply_reset();
        total += 2;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", cfg_ready); end
        if (step_valid !== 1'b0) begin bad++; $display("FAIL rst_step_valid got=%b want=0", step_valid); end
        idle(40);
        clear_counts();
        send_frame(2, 2, -1, 0, 0, 0);
        total += 2;
        if (scale_step !== 16'd0) begin bad++; $display("FAIL stale_step got=%0d want=0", scale_step); end
        if (obs_vs != 0) begin bad++; $display("FAIL stale_vs got=%0d want=0", obs_vs); end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 0; cfg_in_w = '0; cfg_out_w = '0;
        de_i = 0; hs_i = 1; vs_i = 0; di_i = '0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_gating();
        test_first_cfg();
        test_reconfig();
        test_bad_cfg();
        test_lines();
        test_rst_div();
        @(negedge clk); #1;
        total += 1;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
